// File: rtl/mxv_resp_tx.sv
// Response-packet transmitter: frames FE | LEN | CMD | payload | EF and sends each byte as UART 8N1.
// A byte sequencer picks the next frame byte; a bit FSM serialises it (LOAD, START, 8 DATA bits, STOP).
module mxv_resp_tx #(
  parameter int DW       = 8,
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115_200,
  parameter int MAX_N    = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         send,
  input  logic [DW-1:0]                cmd,
  input  logic [$clog2(MAX_N+1)-1:0]   len,
  output logic                         data_pop,
  input  logic [DW-1:0]                Data_Tx,
  output logic                         Serial_Data_Tx,
  output logic                         busy,
  output logic                         done,
  output logic [2:0]                   dbg_seq_state,
  output logic [2:0]                   dbg_bit_state
);

  localparam int CPB = CLK_FREQ / BAUD;
  localparam int CW  = (CPB > 1) ? $clog2(CPB) : 1;
  localparam int NW  = $clog2(MAX_N + 1);
  localparam logic [CW-1:0] CPB_LAST = CW'(CPB - 1);
  localparam logic [NW-1:0] N_MAX    = NW'(MAX_N);
  localparam logic [DW-1:0] HDR_BYTE = DW'(8'hFE);
  localparam logic [DW-1:0] END_BYTE = DW'(8'hEF);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_LEN  = 3'd2,
    S_CMD  = 3'd3,
    S_PAY  = 3'd4,
    S_END  = 3'd5
  } seq_e;

  typedef enum logic [2:0] {
    B_IDLE  = 3'd0,
    B_LOAD  = 3'd1,
    B_START = 3'd2,
    B_DATA  = 3'd3,
    B_STOP  = 3'd4
  } bit_e;

  seq_e            seq_q, seq_d;
  bit_e            bit_q, bit_d;
  logic [CW-1:0]   cpb_cnt_q, cpb_cnt_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [NW-1:0]   pay_cnt_q, pay_cnt_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DW-1:0]   cmd_q, cmd_d;
  logic [DW-1:0]   shift_q, shift_d;
  logic            done_q, done_d;

  logic            bit_last;
  logic [DW-1:0]   byte_val;
  logic [NW-1:0]   pay_nxt;

  // Handshake: data_pop is a 1-cycle strobe in the LOAD cycle of each payload byte; the
  // FIFO presents the byte on Data_Tx one cycle later, where the first START cycle captures it.
  always_comb begin
    byte_val = HDR_BYTE;
    case (seq_q)
      S_HDR:   byte_val = HDR_BYTE;
      S_LEN:   byte_val = DW'(n_q) + DW'(1);
      S_CMD:   byte_val = cmd_q;
      S_PAY:   byte_val = Data_Tx;
      S_END:   byte_val = END_BYTE;
      default: byte_val = HDR_BYTE;
    endcase
  end

  always_comb begin
    seq_d     = seq_q;
    bit_d     = bit_q;
    cpb_cnt_d = cpb_cnt_q;
    bit_cnt_d = bit_cnt_q;
    pay_cnt_d = pay_cnt_q;
    n_d       = n_q;
    cmd_d     = cmd_q;
    shift_d   = shift_q;
    done_d    = 1'b0;
    bit_last  = (cpb_cnt_q == CPB_LAST);
    pay_nxt   = pay_cnt_q + NW'(1);

    case (bit_q)
      B_IDLE: begin
        if (send) begin
          seq_d     = S_HDR;
          bit_d     = B_LOAD;
          cmd_d     = cmd;
          n_d       = (len > N_MAX) ? N_MAX : len;
          pay_cnt_d = '0;
          cpb_cnt_d = '0;
          bit_cnt_d = '0;
        end
      end

      B_LOAD: begin
        bit_d     = B_START;
        cpb_cnt_d = '0;
        bit_cnt_d = '0;
      end

      B_START: begin
        if (cpb_cnt_q == '0) begin
          shift_d = byte_val;
        end
        if (bit_last) begin
          bit_d     = B_DATA;
          cpb_cnt_d = '0;
        end else begin
          cpb_cnt_d = cpb_cnt_q + CW'(1);
        end
      end

      B_DATA: begin
        if (bit_last) begin
          cpb_cnt_d = '0;
          shift_d   = shift_q >> 1;
          if (bit_cnt_q == 3'd7) begin
            bit_d     = B_STOP;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          cpb_cnt_d = cpb_cnt_q + CW'(1);
        end
      end

      B_STOP: begin
        if (bit_last) begin
          cpb_cnt_d = '0;
          bit_d     = B_LOAD;
          case (seq_q)
            S_HDR: seq_d = S_LEN;
            S_LEN: seq_d = S_CMD;
            S_CMD: begin
              pay_cnt_d = '0;
              seq_d     = (n_q == '0) ? S_END : S_PAY;
            end
            S_PAY: begin
              pay_cnt_d = pay_nxt;
              if (pay_nxt == n_q) begin
                seq_d = S_END;
              end
            end
            S_END: begin
              seq_d  = S_IDLE;
              bit_d  = B_IDLE;
              done_d = 1'b1;
            end
            default: begin
              seq_d = S_IDLE;
              bit_d = B_IDLE;
            end
          endcase
        end else begin
          cpb_cnt_d = cpb_cnt_q + CW'(1);
        end
      end

      default: begin
        seq_d = S_IDLE;
        bit_d = B_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seq_q     <= S_IDLE;
      bit_q     <= B_IDLE;
      cpb_cnt_q <= '0;
      bit_cnt_q <= '0;
      pay_cnt_q <= '0;
      n_q       <= '0;
      cmd_q     <= '0;
      shift_q   <= '0;
      done_q    <= 1'b0;
    end else begin
      seq_q     <= seq_d;
      bit_q     <= bit_d;
      cpb_cnt_q <= cpb_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      pay_cnt_q <= pay_cnt_d;
      n_q       <= n_d;
      cmd_q     <= cmd_d;
      shift_q   <= shift_d;
      done_q    <= done_d;
    end
  end

  // Line is decoded from state flops only, so it is high everywhere except START and 0 data bits.
  always_comb begin
    Serial_Data_Tx = 1'b1;
    case (bit_q)
      B_START: Serial_Data_Tx = 1'b0;
      B_DATA:  Serial_Data_Tx = shift_q[0];
      default: Serial_Data_Tx = 1'b1;
    endcase
  end

  assign busy          = (seq_q != S_IDLE);
  assign done          = done_q;
  assign data_pop      = (bit_q == B_LOAD) && (seq_q == S_PAY);
  assign dbg_seq_state = seq_q;
  assign dbg_bit_state = bit_q;

  a_pop_only_in_pay: assert property (@(posedge clk) disable iff (rst)
    data_pop |-> (seq_q == S_PAY));
  a_pay_cnt_bounded: assert property (@(posedge clk) disable iff (rst)
    pay_cnt_q <= n_q);

endmodule

// File: tb/tb_mxv_resp_tx.sv
// Directed bench for mxv_resp_tx at CPB=4: vector table of whole frames plus reset/resend sequences.
module tb_mxv_resp_tx;

  localparam int CPB      = 4;
  localparam int BYTE_CYC = 1 + 10 * CPB;
  localparam int BUDGET   = 700;

  logic       clk = 1'b0;
  logic       rst;
  logic       send;
  logic [7:0] cmd;
  logic [3:0] len;
  logic       data_pop;
  logic [7:0] Data_Tx = 8'h00;
  logic       Serial_Data_Tx;
  logic       busy;
  logic       done;
  logic [2:0] dbg_seq_state;
  logic [2:0] dbg_bit_state;

  mxv_resp_tx #(
    .DW(8), .CLK_FREQ(1_000_000), .BAUD(250_000), .MAX_N(8)
  ) dut (
    .clk(clk), .rst(rst), .send(send), .cmd(cmd), .len(len),
    .data_pop(data_pop), .Data_Tx(Data_Tx), .Serial_Data_Tx(Serial_Data_Tx),
    .busy(busy), .done(done),
    .dbg_seq_state(dbg_seq_state), .dbg_bit_state(dbg_bit_state)
  );

  always #5 clk = ~clk;

  // Registered-read result FIFO model: byte appears on Data_Tx the cycle after a pop.
  logic [7:0] fifo_q[$];
  int         pop_cnt = 0;
  always @(posedge clk) begin
    if (data_pop) begin
      pop_cnt <= pop_cnt + 1;
      if (fifo_q.size() > 0) Data_Tx <= fifo_q.pop_front();
      else Data_Tx <= 8'h00;
    end
  end

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];
  logic       line_log [0:1023];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [7:0]        cmd;
    logic [3:0]        len;
    logic [0:7][7:0]   pay;
    logic [3:0]        npay;
    logic [0:11][7:0]  exp;
    logic [3:0]        nbytes;
    logic [9:0]        cycles;
    logic [7:0]        resend_at;
  } vec_t;

  localparam int NVEC = 6;
  vec_t vecs [NVEC];

  task automatic set_vec(input int i, input logic [7:0] c, input logic [3:0] l,
                         input logic [0:7][7:0] p, input logic [3:0] np,
                         input logic [0:11][7:0] e, input logic [3:0] nb,
                         input logic [9:0] cyc, input logic [7:0] rs);
    vecs[i].cmd = c;  vecs[i].len = l;  vecs[i].pay = p;  vecs[i].npay = np;
    vecs[i].exp = e;  vecs[i].nbytes = nb;  vecs[i].cycles = cyc;  vecs[i].resend_at = rs;
  endtask

  // Sends one frame starting in the current (negedge) cycle and checks everything seen up to done.
  task automatic run_frame(input vec_t v, input string tag);
    int c, done_at, pops, pop_bad, busy_bad, errs, idx;
    logic [7:0] eb, dec;
    logic       eline;
    fifo_q.delete();
    exp_q.delete();
    for (int i = 0; i < int'(v.npay); i++) fifo_q.push_back(v.pay[i]);
    for (int i = 0; i < int'(v.nbytes); i++) exp_q.push_back(v.exp[i]);
    pops = 0; pop_bad = 0; busy_bad = 0; done_at = -1;
    cmd = v.cmd; len = v.len; send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    c = 0;
    while (c < BUDGET) begin
      if (done) begin
        done_at = c;
        break;
      end
      line_log[c] = Serial_Data_Tx;
      if (!busy) busy_bad++;
      if (data_pop) begin
        pops++;
        if (!((c % BYTE_CYC) == 0 && (c / BYTE_CYC) >= 3 && (c / BYTE_CYC) < 3 + int'(v.npay)))
          pop_bad++;
      end
      if (v.resend_at != 8'hFF && c == int'(v.resend_at)) begin
        send = 1'b1; cmd = 8'h77; len = 4'd3;
      end else begin
        send = 1'b0;
      end
      @(negedge clk);
      c++;
    end
    send = 1'b0;
    check({tag, " done_cycle"}, done_at, int'(v.cycles));
    check({tag, " busy_low_in_frame"}, busy_bad, 0);
    check({tag, " pop_count"}, pops, int'(v.npay));
    check({tag, " pop_position"}, pop_bad, 0);
    check({tag, " busy_at_done"}, busy, 1'b0);
    for (int b = 0; exp_q.size() > 0; b++) begin
      eb = exp_q.pop_front();
      errs = 0;
      for (int t = 0; t < BYTE_CYC; t++) begin
        idx = b * BYTE_CYC + t;
        if (t == 0) eline = 1'b1;
        else if (t < 5) eline = 1'b0;
        else if (t < 37) eline = eb[(t - 5) / 4];
        else eline = 1'b1;
        if (idx >= c || line_log[idx] !== eline) errs++;
      end
      for (int k = 0; k < 8; k++) dec[k] = line_log[b * BYTE_CYC + 5 + 4 * k + 2];
      check($sformatf("%s byte%0d_value", tag, b), dec, eb);
      check($sformatf("%s byte%0d_waveform_errs", tag, b), errs, 0);
    end
    if (v.resend_at != 8'hFF) begin
      @(negedge clk);
      check({tag, " no_queued_frame"}, busy, 1'b0);
    end
  endtask

  task automatic reset_mid_frame();
    int pre, done_seen, low_seen;
    fifo_q.delete();
    fifo_q.push_back(8'h11);
    fifo_q.push_back(8'h22);
    pre = pop_cnt;
    cmd = 8'h35; len = 4'd2; send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    repeat (100) @(negedge clk);
    // Cycle 100 of the frame is DATA bit 3 of CMD 0x35, a 0 bit.
    check("rst cmd_bit3_line", Serial_Data_Tx, 1'b0);
    check("rst busy_before", busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst line_high", Serial_Data_Tx, 1'b1);
    check("rst busy_low", busy, 1'b0);
    check("rst done_low", done, 1'b0);
    done_seen = 0; low_seen = 0;
    repeat (300) begin
      @(negedge clk);
      if (done) done_seen++;
      if (!Serial_Data_Tx) low_seen++;
    end
    check("rst no_done", done_seen, 0);
    check("rst line_idle_high", low_seen, 0);
    check("rst no_pops", pop_cnt - pre, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    set_vec(0, 8'h03, 4'd2, {8'h12, 8'h34, 48'h0}, 4'd2,
            {8'hFE, 8'h03, 8'h03, 8'h12, 8'h34, 8'hEF, 48'h0}, 4'd6, 10'd246, 8'hFF);
    set_vec(1, 8'h05, 4'd0, 64'h0, 4'd0,
            {8'hFE, 8'h01, 8'h05, 8'hEF, 64'h0}, 4'd4, 10'd164, 8'hFF);
    set_vec(2, 8'h05, 4'd0, 64'h0, 4'd0,
            {8'hFE, 8'h01, 8'h05, 8'hEF, 64'h0}, 4'd4, 10'd164, 8'd10);
    set_vec(3, 8'h5A, 4'd11, {8'hA5, 8'h5A, 8'h00, 8'hFF, 8'h01, 8'h80, 8'hC3, 8'h3C}, 4'd8,
            {8'hFE, 8'h09, 8'h5A, 8'hA5, 8'h5A, 8'h00, 8'hFF, 8'h01, 8'h80, 8'hC3, 8'h3C, 8'hEF},
            4'd12, 10'd492, 8'hFF);
    set_vec(4, 8'hA5, 4'd1, {8'hA5, 56'h0}, 4'd1,
            {8'hFE, 8'h02, 8'hA5, 8'hA5, 8'hEF, 56'h0}, 4'd5, 10'd205, 8'hFF);
    set_vec(5, 8'hC0, 4'd8, {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08}, 4'd8,
            {8'hFE, 8'h09, 8'hC0, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'hEF},
            4'd12, 10'd492, 8'hFF);

    rst = 1'b1; send = 1'b0; cmd = 8'h00; len = 4'd0;
    repeat (3) @(negedge clk);
    check("reset line", Serial_Data_Tx, 1'b1);
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset data_pop", data_pop, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // Frames go back-to-back: each new send lands in the previous frame's done cycle.
    for (int i = 0; i < NVEC; i++) run_frame(vecs[i], $sformatf("vec%0d", i));

    repeat (5) @(negedge clk);
    reset_mid_frame();
    run_frame(vecs[0], "recover");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
